// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port framebuffer RAM among three users on an 800x600
// display. The users, from highest to lowest priority, are:
//   - scanout reads: one read for every 4x4-pixel framebuffer cell
//   - the optional clear engine, which writes zero to every cell
//   - a generic pixel writer with a valid/ready handshake
//
// Scanout is pipelined. A read is issued at t, the RAM sees the address at
// t+1, read data comes back at t+2 and pix shows it at t+3. pix keeps that
// value for all four columns of the cell and is 0 outside the active area.
//
// Optional feature: define VGA_FB_CLEAR_EN to build in the clear FSM. When it
// is not defined, clear_req is ignored and clear_busy is tied to 0.
//
// Parameters:
//   FB_W, FB_H  framebuffer size in cells (default 200 x 150)
//   DW          pixel data width
//   AW          framebuffer address width
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   x, y               current column and row from the 800x600 timing generator
//   wr_valid/wr_ready  writer handshake (wr_ready is combinational)
//   wr_addr, wr_data   writer address and pixel value
//   wr_err             sticky flag: an out-of-range write was dropped
//   clear_req          one-cycle pulse that starts a framebuffer clear
//   clear_busy         high while a clear is running
//   mem_addr/we/wdata  registered RAM command
//   mem_rdata          RAM read data, one cycle after mem_addr
//   pix                scanout pixel
//   vblank             registered, high while y >= 600
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int FB_W = 200,
    parameter int FB_H = 150,
    parameter int DW   = 8,
    parameter int AW   = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_err,
    input  logic          clear_req,
    output logic          clear_busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix,
    output logic          vblank
);

    localparam int            NPIX   = FB_W * FB_H;
    localparam logic [AW:0]   NPIX_W = (AW+1)'(NPIX);

    logic          active;
    logic          fetch;
    logic [AW-1:0] fetch_addr;
    logic          wr_fire;
    logic          wr_in_range;
    logic          clear_write;
    logic [AW-1:0] clear_addr;
    logic          act_d1;
    logic          act_d2;
    logic          fetch_d1;
    logic          fetch_d2;

    // Scanout gets the first cycle of every 4-column cell in the active
    // area. The address is the cell index: row of cells times the
    // framebuffer width, plus the column of the cell.
    assign active     = (x < 11'd800) && (y < 11'd600);
    assign fetch      = active && (x[1:0] == 2'b00);
    assign fetch_addr = AW'(32'(y[10:2]) * 32'(FB_W) + 32'(x[10:2]));

    // The writer only gets cycles that scanout and the clear engine leave
    // free. An out-of-range write still completes the handshake, so the
    // writer is never stuck, but it is dropped and flagged.
    assign wr_ready    = !fetch && !clear_busy && !rst;
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = ({1'b0, wr_addr} < NPIX_W);

`ifdef VGA_FB_CLEAR_EN
    typedef enum logic {
        IDLE,
        CLEAR
    } clear_state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

    clear_state_t  state;
    logic [AW-1:0] clear_cnt;

    // Clear engine. It walks through every cell once and writes zero on
    // every cycle that scanout does not need. A clear_req that arrives
    // while a clear is running is ignored. clear_busy is registered
    // together with the state, so it is high exactly while in CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            clear_cnt  <= '0;
            clear_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clear_cnt  <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (!fetch) begin
                        clear_cnt <= clear_cnt + 1'b1;
                        if (clear_cnt == LAST_ADDR) begin
                            state      <= IDLE;
                            clear_busy <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign clear_write = (state == CLEAR) && !fetch;
    assign clear_addr  = clear_cnt;
`else
    logic unused_clear_req;

    assign unused_clear_req = clear_req;
    assign clear_busy       = 1'b0;
    assign clear_write      = 1'b0;
    assign clear_addr       = '0;
`endif

    // RAM command register, in priority order: scanout read, clear write,
    // then writer. When nobody uses the RAM the address is held and the
    // write enable drops. mem_wdata only changes when a write is issued.
    // The sticky error flag lives here because it is set by the same
    // handshake that would otherwise have issued the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wr_err    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (fetch) begin
                mem_addr <= fetch_addr;
            end else if (clear_write) begin
                mem_addr  <= clear_addr;
                mem_we    <= 1'b1;
                mem_wdata <= '0;
            end else if (wr_fire) begin
                if (wr_in_range) begin
                    mem_addr  <= wr_addr;
                    mem_we    <= 1'b1;
                    mem_wdata <= wr_data;
                end else begin
                    wr_err <= 1'b1;
                end
            end
        end
    end

    // Scanout alignment. The active and fetch flags travel two stages so
    // that they line up with the read data. On a fetch stage pix loads the
    // read data. On the other stages of an active cell pix holds its value.
    // Outside the active area pix is forced to 0. Reset empties the
    // pipeline, so nothing sampled before reset reaches pix.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_d1   <= 1'b0;
            act_d2   <= 1'b0;
            fetch_d1 <= 1'b0;
            fetch_d2 <= 1'b0;
            pix      <= '0;
            vblank   <= 1'b0;
        end else begin
            act_d1   <= active;
            act_d2   <= act_d1;
            fetch_d1 <= fetch;
            fetch_d2 <= fetch_d1;
            vblank   <= (y >= 11'd600);
            if (!act_d2) begin
                pix <= '0;
            end else if (fetch_d2) begin
                pix <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameter FB_W, default 200: framebuffer width in pixels.
REQ-002 Parameter FB_H, default 150: framebuffer height in pixels.
REQ-003 Parameter DW, default 8: pixel data width.
REQ-004 Parameter AW, default 15: framebuffer address width.
REQ-005 Port clk  input  1: single clock; all logic on rising edge.
REQ-006 Port rst  input  1: reset, synchronous, active-high.
REQ-007 Port x  input  11: current column from the 800x600 timing generator.
REQ-008 Port y  input  11: current row from the timing generator.
REQ-009 Port wr_valid  input  1: writer request.
REQ-010 Port wr_ready  output  1: writer grant.
REQ-011 Port wr_addr  input  AW: writer pixel address.
REQ-012 Port wr_data  input  DW: writer pixel value.
REQ-013 Port wr_err  output  1: sticky flag, an out-of-range write was dropped.
REQ-014 Port clear_req  input  1: single-cycle pulse that starts a framebuffer clear.
REQ-015 Port clear_busy  output  1: clear in progress.
REQ-016 Port mem_addr  output  AW: registered RAM address.
REQ-017 Port mem_we  output  1: registered RAM write enable.
REQ-018 Port mem_wdata  output  DW: registered RAM write data.
REQ-019 Port mem_rdata  input  DW: RAM read data, one cycle after mem_addr.
REQ-020 Port pix  output  DW: scanout pixel.
REQ-021 Port vblank  output  1: registered, high while y >= 600.

Function
REQ-022 The block SHALL define active area as x < 800 and y < 600; each framebuffer pixel covers 4x4 screen pixels.
REQ-023 A fetch slot SHALL be any cycle with active area and x[1:0] == 0.
REQ-024 In a fetch slot the block SHALL issue a read: mem_addr = (y>>2)*FB_W + (x>>2) and mem_we = 0, both registered next cycle.
REQ-025 pix SHALL correspond to the x,y sampled 3 cycles earlier: issue at t, RAM at t+1, rdata at t+2, pix at t+3.
REQ-026 pix SHALL hold its value for the 4 columns of a cell and SHALL be 0 for positions outside the active area, using the same 3-cycle alignment.
REQ-027 Priority per cycle SHALL be fetch > clear > writer.
REQ-028 wr_ready SHALL be combinational: 1 only when the cycle is not a fetch slot, clear_busy = 0 and rst = 0.
REQ-029 A write SHALL transfer when wr_valid and wr_ready are both 1.
REQ-030 A write with wr_addr < FB_W*FB_H SHALL produce mem_we = 1 with wr_addr/wr_data on the next cycle.
REQ-031 A write with wr_addr >= FB_W*FB_H SHALL complete the handshake, SHALL NOT assert mem_we, and SHALL set wr_err.
REQ-032 The writer SHALL hold wr_valid, wr_addr and wr_data stable until the transfer.
REQ-033 On idle cycles mem_we SHALL be 0 and mem_addr SHALL hold its last value.
REQ-034 The clear FSM SHALL have two states, IDLE and CLEAR.
REQ-035 IDLE -> CLEAR on clear_req; the clear address counter starts at 0.
REQ-036 In CLEAR, each non-fetch cycle SHALL write 0 to the counter address, then increment the counter.
REQ-037 CLEAR -> IDLE after the write to address FB_W*FB_H-1; clear_busy SHALL be 1 exactly in CLEAR.
REQ-038 clear_req while in CLEAR SHALL be ignored.
REQ-039 If clear_req and wr_valid are asserted in the same cycle in IDLE, the write SHALL transfer only if that cycle is otherwise granted, and CLEAR SHALL start on the next cycle.

Reset
REQ-040 On rst, outputs SHALL take these values on the next edge:
  - mem_we=0, mem_addr=0, mem_wdata=0, pix=0
  - wr_err=0, vblank=0, clear_busy=0
  - FSM=IDLE, clear counter=0, pipeline valid bits cleared
REQ-041 rst asserted during CLEAR SHALL abort the clear with no further writes.

Configuration
REQ-042 With macro VGA_FB_CLEAR_EN defined, the clear FSM (REQ-034..REQ-039, REQ-041) SHALL be compiled in.
REQ-043 Without VGA_FB_CLEAR_EN, clear_req SHALL be ignored, clear_busy SHALL be tied to 0, and no FSM logic SHALL exist.

Verification
REQ-044 x=0,y=0 active, mem_rdata=8'h5A at t+2 -> mem_addr=0 at t+1; pix=8'h5A at t+3 through t+6.
REQ-045 x=8,y=4 -> mem_addr=202; wr_valid held during x=8 -> wr_ready=0 at x=8, transfer at x=9, mem_we=1 at x=10.
REQ-046 wr_addr=30000 granted -> no mem_we; wr_err=1 until rst.
REQ-047 clear_req in vblank with VGA_FB_CLEAR_EN -> 30000 zero writes to addresses 0..29999; clear_busy drops after the last write; wr_ready=0 throughout the clear.
REQ-048 rst pulsed mid-clear at counter=1000 -> mem_we=0 the next cycle; clear_busy=0.
REQ-049 x=800..1055 or y>=600 -> no reads issued, pix=0, wr_ready=1 when no clear is running; vblank=1 for y>=600.
